// File: rtl/cpu_control_unit.sv
// cpu_control_unit: registered decoder from instruction class code to datapath controls.
// Codes 12-15 are illegal and decode to an all-zero NOP.
module cpu_control_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] signalCommand,
   output logic       jump,
   output logic       jr_sel,
   output logic       jal_sel_d,
   output logic       jal_sel_addr,
   output logic       mem_to_reg,
   output logic       mem_write,
   output logic       branch,
   output logic [2:0] alu_sel,
   output logic [2:0] alui_sel,
   output logic       alu_src_sel,
   output logic       reg_dest
);
   localparam logic [3:0] OP_LW = 4'd0, OP_SW = 4'd1, OP_J = 4'd2, OP_JR = 4'd3,
                          OP_JAL = 4'd4, OP_BEQ = 4'd5, OP_BNE = 4'd6, OP_XORI = 4'd7,
                          OP_ADDI = 4'd8, OP_ADD = 4'd9, OP_SUB = 4'd10, OP_SLT = 4'd11;
   logic [3:0]  w_op;
   logic [14:0] w_ctl;
   logic [14:0] r_ctl;
   logic [2:0]  w_alu_sel;
   logic [2:0]  w_alui_sel;
   assign w_op = signalCommand;
   assign w_alu_sel = (w_op == OP_BNE)                    ? 3'b110 :
                      (w_op == OP_BEQ || w_op == OP_SUB)  ? 3'b001 :
                      (w_op == OP_XORI)                   ? 3'b010 :
                      (w_op == OP_SLT)                    ? 3'b011 : 3'b000;
   assign w_alui_sel = (w_op == OP_XORI) ? 3'b010 : 3'b000;
   // Illegal codes match none of the terms below, so every field falls to 0.
   assign w_ctl = {
      w_op == OP_J || w_op == OP_JR || w_op == OP_JAL,
      w_op == OP_JR,
      w_op == OP_JAL,
      w_op == OP_JAL,
      w_op == OP_LW,
      w_op == OP_SW,
      w_op == OP_BEQ || w_op == OP_BNE,
      w_alu_sel,
      w_alui_sel,
      w_op == OP_LW || w_op == OP_SW || w_op == OP_ADDI || w_op == OP_XORI,
      w_op == OP_ADD || w_op == OP_SUB || w_op == OP_SLT
   };
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ctl <= '0;
      else        r_ctl <= w_ctl;
   end
   assign {jump, jr_sel, jal_sel_d, jal_sel_addr, mem_to_reg, mem_write, branch,
           alu_sel, alui_sel, alu_src_sel, reg_dest} = r_ctl;
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed opcodes feed a scoreboard queue; a monitor compares one cycle later.
// Reset behaviour is checked directly around asynchronous rst_n pulses.
module tb_cpu_control_unit;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] signalCommand = 4'd12;
   logic       jump, jr_sel, jal_sel_d, jal_sel_addr, mem_to_reg, mem_write, branch;
   logic [2:0] alu_sel, alui_sel;
   logic       alu_src_sel, reg_dest;
   logic [14:0] w_act;
   logic [14:0] exp_tab [16];
   logic [14:0] q [$];
   bit         mon_en = 1'b0;
   int         checks = 0;
   int         errors = 0;

   cpu_control_unit dut (
      .clk(clk), .rst_n(rst_n), .signalCommand(signalCommand),
      .jump(jump), .jr_sel(jr_sel), .jal_sel_d(jal_sel_d), .jal_sel_addr(jal_sel_addr),
      .mem_to_reg(mem_to_reg), .mem_write(mem_write), .branch(branch),
      .alu_sel(alu_sel), .alui_sel(alui_sel), .alu_src_sel(alu_src_sel), .reg_dest(reg_dest)
   );

   always #5 clk = ~clk;

   assign w_act = {jump, jr_sel, jal_sel_d, jal_sel_addr, mem_to_reg, mem_write, branch,
                   alu_sel, alui_sel, alu_src_sel, reg_dest};

   // Field order: jump jr jal_d jal_addr m2r mw br | alu[3] | alui[3] | src dest
   initial begin
      exp_tab[0]  = {7'b0000100, 3'b000, 3'b000, 2'b10};
      exp_tab[1]  = {7'b0000010, 3'b000, 3'b000, 2'b10};
      exp_tab[2]  = {7'b1000000, 3'b000, 3'b000, 2'b00};
      exp_tab[3]  = {7'b1100000, 3'b000, 3'b000, 2'b00};
      exp_tab[4]  = {7'b1011000, 3'b000, 3'b000, 2'b00};
      exp_tab[5]  = {7'b0000001, 3'b001, 3'b000, 2'b00};
      exp_tab[6]  = {7'b0000001, 3'b110, 3'b000, 2'b00};
      exp_tab[7]  = {7'b0000000, 3'b010, 3'b010, 2'b10};
      exp_tab[8]  = {7'b0000000, 3'b000, 3'b000, 2'b10};
      exp_tab[9]  = {7'b0000000, 3'b000, 3'b000, 2'b01};
      exp_tab[10] = {7'b0000000, 3'b001, 3'b000, 2'b01};
      exp_tab[11] = {7'b0000000, 3'b011, 3'b000, 2'b01};
      for (int i = 12; i < 16; i++) exp_tab[i] = '0;
   end

   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op);
      @(negedge clk);
      signalCommand = op;
      q.push_back(exp_tab[op]);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left expected 0", q.size());
         q.delete();
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en && q.size() != 0) begin
         check("decode", w_act, q.pop_front());
         check("jump_and_branch", {14'd0, jump & branch}, 15'd0);
         check("mw_and_m2r", {14'd0, mem_write & mem_to_reg}, 15'd0);
      end
   end

   initial begin
      #1 rst_n = 1'b0;
      #1 check("reset_async", w_act, 15'd0);
      signalCommand = 4'd0;
      repeat (2) @(posedge clk);
      #1 check("reset_hold", w_act, 15'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("reset_release_pre_edge", w_act, 15'd0);
      mon_en = 1'b1;
      for (int op = 0; op < 16; op++) drive(op[3:0]);
      drive(4'd13);
      drive(4'd9);
      drive(4'd10);
      drive(4'd7);
      drive(4'd6);
      drive(4'd15);
      drive(4'd4);
      drain();
      // Mid-stream reset with LW held: async drop, hold through release, then LW again.
      drive(4'd0);
      drain();
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("midreset_async", w_act, 15'd0);
      #1 rst_n = 1'b1;
      #1 check("midreset_released", w_act, 15'd0);
      @(posedge clk);
      #1 check("midreset_lw", w_act, exp_tab[0]);
      // Pending SUB is discarded; SLT at the first post-reset edge decodes first.
      @(negedge clk);
      signalCommand = 4'd10;
      rst_n = 1'b0;
      @(posedge clk);
      #1 check("reset_discard", w_act, 15'd0);
      @(negedge clk);
      rst_n = 1'b1;
      signalCommand = 4'd11;
      @(posedge clk);
      #1 check("post_reset_first", w_act, exp_tab[11]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu_control_unit.md
CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 signalCommand  input  4  decoded instruction class code.
REQ-004 jump  output  1  PC takes a jump target.
REQ-005 jr_sel  output  1  jump target comes from register (JR).
REQ-006 jal_sel_d  output  1  write-back destination forced to $31.
REQ-007 jal_sel_addr  output  1  write-back data is PC+4 (link).
REQ-008 mem_to_reg  output  1  write-back data comes from data memory.
REQ-009 mem_write  output  1  data-memory write enable.
REQ-010 branch  output  1  conditional branch instruction.
REQ-011 alu_sel  output  3  ALU operation.
REQ-012 alui_sel  output  3  immediate-class ALU operation; 000 for non-immediate classes.
REQ-013 alu_src_sel  output  1  1 = ALU operand B is the sign-extended immediate, 0 = register rt.
REQ-014 reg_dest  output  1  1 = destination register is rd, 0 = rt.

Function
REQ-015 Opcode encoding SHALL be: LW=0, SW=1, J=2, JR=3, JAL=4, BEQ=5, BNE=6, XORI=7, ADDI=8, ADD=9, SUB=10, SLT=11; codes 12-15 are illegal.
REQ-016 ALU codes SHALL be: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 110 SUB with inverted zero sense (BNE); 100, 101 and 111 are reserved and never driven.
REQ-017 Each output listed below SHALL be 1 for the stated opcodes and 0 for all others:
- jump: J, JR, JAL.
- jr_sel: JR.
- jal_sel_d and jal_sel_addr: JAL.
- mem_to_reg: LW.
- mem_write: SW.
- branch: BEQ, BNE.
- alu_src_sel: LW, SW, ADDI, XORI.
- reg_dest: ADD, SUB, SLT.
REQ-018 alu_sel SHALL be:
- 000 for LW, SW, J, JR, JAL, ADD, ADDI.
- 001 for BEQ and SUB.
- 110 for BNE.
- 010 for XORI.
- 011 for SLT.
REQ-019 alui_sel SHALL be 000 for ADDI, 010 for XORI, and 000 for all other opcodes.
REQ-020 Illegal opcodes (12-15) SHALL produce all outputs 0 (NOP: no write, no jump, no branch).
REQ-021 All outputs SHALL be registered, with signalCommand sampled on each rising clk edge.
REQ-022 Decoded values SHALL appear at the outputs exactly 1 cycle after the sampling edge and hold until the next edge.
REQ-023 A new opcode every cycle SHALL be supported with no stalls, and each cycle's outputs SHALL depend only on the opcode sampled at the previous edge.
REQ-024 jump and branch SHALL never both be 1, and mem_write and mem_to_reg SHALL never both be 1.

Reset
REQ-025 While rst_n=0, all outputs SHALL be 0 immediately, without waiting for clk.
REQ-026 Outputs SHALL stay 0 until the first rising clk edge after rst_n returns to 1; that edge samples signalCommand normally.
REQ-027 Reset asserted mid-stream SHALL discard the pending decode, and the opcode present at the first post-reset edge SHALL be the first one decoded.

Verification
REQ-028 LW, then a clk edge -> mem_to_reg=1, alu_src_sel=1, alu_sel=000, all other outputs 0; SW -> mem_write=1, alu_src_sel=1, all other outputs 0.
REQ-029 BEQ -> branch=1, alu_sel=001; BNE -> branch=1, alu_sel=110; in both cases alu_src_sel=0 and reg_dest=0.
REQ-030 J -> jump=1 only; JR -> jump=1, jr_sel=1; JAL -> jump=1, jal_sel_d=1, jal_sel_addr=1; all other outputs 0 in each case.
REQ-031 ADD -> reg_dest=1, alu_sel=000; ADDI -> alu_src_sel=1, alui_sel=000; XORI -> alu_src_sel=1, alu_sel=010, alui_sel=010; SLT -> reg_dest=1, alu_sel=011.
REQ-032 Hold opcode LW and pulse rst_n low between clk edges -> outputs drop to 0 asynchronously, stay 0 until the next edge after release, then return to the LW pattern.
REQ-033 Apply code 13, then a clk edge -> all outputs 0; apply ADD then SUB on consecutive edges -> alu_sel goes 000 then 001, each one cycle after its sampling edge.
